conv3x3_engine: RTL and testbench

Window-consumer and result-producer for the padded-frame window memory. On `start` it drives `rd` for exactly one full frame of window reads, receives the nine 3×3 window pixels one cycle after each read, and filters them through a two-stage pipeline. The filter is a 1-2-1 Gaussian smooth or a Sobel magnitude. Each result is written back over the memory's `wr`/`pixelw` write port. It is the initiator for both memory ports; the memory is the responder.

---
 rtl/conv3x3_engine.sv | 147 ++++++++++++++
 tb/tb_conv3x3_engine.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_engine.sv
// 3x3 window filter engine: streams one frame of window reads, applies a Gaussian
// or Sobel-magnitude filter through a two-stage pipeline and writes each result back.
module conv3x3_engine #(
  parameter int IMG_W    = 256,
  parameter int IMG_ROWS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic [7:0] pixelr1,
  input  logic [7:0] pixelr2,
  input  logic [7:0] pixelr3,
  input  logic [7:0] pixelr4,
  input  logic [7:0] pixelr5,
  input  logic [7:0] pixelr6,
  input  logic [7:0] pixelr7,
  input  logic [7:0] pixelr8,
  input  logic [7:0] pixelr9,
  output logic       rd,
  output logic       wr,
  output logic [7:0] pixelw,
  output logic       busy,
  output logic       done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [1:0]        drain_q, drain_d;
  logic              mode_q, mode_d;
  logic [2:0]        vld_q;
  logic [11:0]       g_q;
  logic signed [10:0] gx_q, gy_q;
  logic [7:0]        pix_q;

  logic              lastWin;
  logic [11:0]       gSum;
  logic [10:0]       xPos, xNeg, yPos, yNeg;
  logic signed [10:0] gxSum, gySum;
  logic [10:0]       absX, absY, sobSum;
  logic [7:0]        pixNext;

  assign lastWin = (row_q == RW'(IMG_ROWS - 1)) && (col_q == CW'(IMG_W - 1));

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    drain_d = drain_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          mode_d  = mode;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_READ: begin
        if (lastWin) begin
          state_d = S_DRAIN;
          col_d   = '0;
          row_d   = '0;
          drain_d = '0;
        end else if (col_q == CW'(IMG_W - 1)) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == 2'd2) state_d = S_DONE;
        else                 drain_d = drain_q + 2'd1;
      end
      default: begin
        state_d = S_IDLE;
        drain_d = '0;
      end
    endcase
  end

  // Stage-1 sums; Sobel differences fit 11-bit two's complement since |G| <= 1020.
  always_comb begin
    gSum = 12'(pixelr1) + (12'(pixelr2) << 1) + 12'(pixelr3)
         + (12'(pixelr4) << 1) + (12'(pixelr5) << 2) + (12'(pixelr6) << 1)
         + 12'(pixelr7) + (12'(pixelr8) << 1) + 12'(pixelr9);
    xPos  = 11'(pixelr3) + (11'(pixelr6) << 1) + 11'(pixelr9);
    xNeg  = 11'(pixelr1) + (11'(pixelr4) << 1) + 11'(pixelr7);
    yPos  = 11'(pixelr7) + (11'(pixelr8) << 1) + 11'(pixelr9);
    yNeg  = 11'(pixelr1) + (11'(pixelr2) << 1) + 11'(pixelr3);
    gxSum = xPos - xNeg;
    gySum = yPos - yNeg;
  end

  always_comb begin
    absX    = gx_q[10] ? 11'(-gx_q) : 11'(gx_q);
    absY    = gy_q[10] ? 11'(-gy_q) : 11'(gy_q);
    sobSum  = absX + absY;
    pixNext = mode_q ? ((sobSum > 11'd255) ? 8'hFF : sobSum[7:0]) : 8'(g_q >> 4);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      drain_q <= '0;
      mode_q  <= 1'b0;
      vld_q   <= '0;
      g_q     <= '0;
      gx_q    <= '0;
      gy_q    <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      drain_q <= drain_d;
      mode_q  <= mode_d;
      vld_q   <= {vld_q[1:0], rd};
      if (vld_q[0]) begin
        g_q  <= gSum;
        gx_q <= gxSum;
        gy_q <= gySum;
      end
      if (vld_q[1]) pix_q <= pixNext;
    end
  end

  assign rd     = (state_q == S_READ);
  assign busy   = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done   = (state_q == S_DONE);
  assign wr     = vld_q[2];
  assign pixelw = pix_q;

endmodule

// File: tb/tb_conv3x3_engine.sv
// Directed bench for conv3x3_engine: a window-memory model feeds fixed patterns and
// a queue of hand-computed results is checked against every write.
module tb_conv3x3_engine;

  localparam int N = 256 * 32;

  logic       clk = 1'b0;
  logic       rst, start, mode;
  logic [7:0] pr [9];
  logic       rd, wr, busy, done;
  logic [7:0] pixelw;

  logic [7:0] patA [9];
  logic [7:0] patB [9];
  logic [7:0] expA, expB;
  logic [7:0] expQ [$];
  logic       sel = 1'b0;

  int cycNow = 0, startCyc = 0;
  int rdCount, firstRd, lastRd, wrCount, firstWr, lastWr, badCount, doneCount, doneCyc, busyCount;
  int compared = 0, mismatched = 0;

  conv3x3_engine dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .pixelr1(pr[0]), .pixelr2(pr[1]), .pixelr3(pr[2]),
    .pixelr4(pr[3]), .pixelr5(pr[4]), .pixelr6(pr[5]),
    .pixelr7(pr[6]), .pixelr8(pr[7]), .pixelr9(pr[8]),
    .rd(rd), .wr(wr), .pixelw(pixelw), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycNow <= cycNow + 1;

  // Memory model: alternates between two patterns, answering each read one cycle later.
  always @(posedge clk) begin
    if (rd) begin
      for (int i = 0; i < 9; i++) pr[i] <= sel ? patB[i] : patA[i];
      expQ.push_back(sel ? expB : expA);
      sel <= ~sel;
    end
  end

  always @(negedge clk) begin
    int rel;
    logic [7:0] e;
    rel = cycNow - startCyc;
    if (rd) begin
      rdCount++;
      if (firstRd < 0) firstRd = rel;
      lastRd = rel;
    end
    if (busy) busyCount++;
    if (wr) begin
      wrCount++;
      if (firstWr < 0) firstWr = rel;
      lastWr = rel;
      if (expQ.size() == 0) badCount++;
      else begin
        e = expQ.pop_front();
        if (pixelw != e) badCount++;
      end
    end
    if (done) begin
      doneCount++;
      doneCyc = rel;
    end
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    compared++;
    if (obs != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clearStats();
    rdCount = 0; firstRd = -1; lastRd = -1;
    wrCount = 0; firstWr = -1; lastWr = -1;
    badCount = 0; doneCount = 0; doneCyc = -1; busyCount = 0;
  endtask

  // Starts a frame and runs lastRel cycles; noise injects ignored starts and mode flips.
  task automatic applyStimulus(input logic m, input bit noise, input int lastRel);
    @(negedge clk);
    clearStats();
    expQ.delete();
    startCyc = cycNow;
    start = 1'b1;
    mode  = m;
    for (int k = 1; k <= lastRel; k++) begin
      @(negedge clk);
      start = 1'b0;
      mode  = m;
      if (noise && (k == 100 || k == 4000 || k == N + 2 || k == N + 4)) begin
        start = 1'b1;
        mode  = ~m;
      end else if (noise && k > 200 && k < 300) begin
        mode = ~m;
      end
    end
    start = 1'b0;
  endtask

  task automatic checkFrame(input string tag);
    @(posedge clk);
    #1;
    checkOutput({tag, " rdCount"},   rdCount,   N);
    checkOutput({tag, " firstRd"},   firstRd,   1);
    checkOutput({tag, " lastRd"},    lastRd,    N);
    checkOutput({tag, " wrCount"},   wrCount,   N);
    checkOutput({tag, " firstWr"},   firstWr,   4);
    checkOutput({tag, " lastWr"},    lastWr,    N + 3);
    checkOutput({tag, " badPixels"}, badCount,  0);
    checkOutput({tag, " doneCount"}, doneCount, 1);
    checkOutput({tag, " doneCyc"},   doneCyc,   N + 4);
    checkOutput({tag, " busyCount"}, busyCount, N + 3);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0;
    for (int i = 0; i < 9; i++) begin
      pr[i] = 8'd0; patA[i] = 8'd0; patB[i] = 8'd0;
    end
    expA = 8'd0; expB = 8'd0;
    clearStats();
    repeat (3) @(negedge clk);
    checkOutput("reset rd",     int'(rd),     0);
    checkOutput("reset wr",     int'(wr),     0);
    checkOutput("reset busy",   int'(busy),   0);
    checkOutput("reset done",   int'(done),   0);
    checkOutput("reset pixelw", int'(pixelw), 0);
    rst = 1'b0;

    patA = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100};
    patB = patA; expA = 8'd100; expB = 8'd100;
    applyStimulus(1'b0, 1'b0, N + 8);
    checkFrame("gauss100");

    patA = '{8'd77, 8'd77, 8'd77, 8'd77, 8'd77, 8'd77, 8'd77, 8'd77, 8'd77};
    patB = patA; expA = 8'd0; expB = 8'd0;
    applyStimulus(1'b1, 1'b0, N + 8);
    checkFrame("sobelFlat");

    patA = '{8'd0, 8'd128, 8'd255, 8'd0, 8'd128, 8'd255, 8'd0, 8'd128, 8'd255};
    patB = '{8'd255, 8'd128, 8'd0, 8'd255, 8'd128, 8'd0, 8'd255, 8'd128, 8'd0};
    expA = 8'd255; expB = 8'd255;
    applyStimulus(1'b1, 1'b0, N + 8);
    checkFrame("sobelSat");

    patA = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0};
    patB = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    expA = 8'd63; expB = 8'd255;
    applyStimulus(1'b0, 1'b1, N + 8);
    checkFrame("gaussNoise");

    patA = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100};
    patB = patA; expA = 8'd100; expB = 8'd100;
    applyStimulus(1'b0, 1'b0, 500);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midReset rd",   int'(rd),   0);
    checkOutput("midReset wr",   int'(wr),   0);
    checkOutput("midReset busy", int'(busy), 0);
    checkOutput("midReset done", int'(done), 0);
    clearStats();
    expQ.delete();
    repeat (20) @(negedge clk);
    @(posedge clk);
    #1;
    checkOutput("postReset wrCount", wrCount, 0);
    checkOutput("postReset rdCount", rdCount, 0);

    patA = '{8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    patB = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd50};
    expA = 8'd20; expB = 8'd100;
    applyStimulus(1'b1, 1'b0, N + 8);
    checkFrame("sobelMid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
